// File: rtl/countdown_4_if.sv
// Control/status bundle for the loadable down-counter.
// The master side is the controller; the slave side is the counter.
interface countdown_4_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             hold;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output clear, load, load_val, hold,
    input  count, busy, done
  );

  modport slave (
    input  clear, load, load_val, hold,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_4.sv
// Loadable down-counter with a one-cycle done pulse at zero and optional auto-reload.
// Edge priority: clear, then load, then hold, then the per-state action.
module countdown_4 #(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input logic           clk,
  input logic           rst,
  countdown_4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state    <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count_q;
    reload_n = reload_q;
    if (bus.clear) begin
      state_n = IDLE;
      count_n = '0;
    end else if (bus.load) begin
      reload_n = bus.load_val;
      count_n  = bus.load_val;
      state_n  = (bus.load_val != '0) ? RUN : DONE;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          if (!bus.hold) begin
            // zero is never decremented; reaching one ends the run on this edge
            if (count_q != '0) count_n = count_q - WIDTH'(1);
            if (count_q <= WIDTH'(1)) state_n = DONE;
          end
        end
        DONE: begin
          if (AUTO_RELOAD && (reload_q != '0)) begin
            count_n = reload_q;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_countdown_4.sv
// Directed bench for countdown_4: one instance without and one with auto-reload.
module tb_countdown_4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  countdown_4_if #(.WIDTH(4)) if0 ();
  countdown_4_if #(.WIDTH(4)) if1 ();

  countdown_4 #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  countdown_4 #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] c, input logic b, input logic d,
                     input logic [3:0] ec, input logic eb, input logic ed);
    checks++;
    assert (c === ec) else begin
      failures++;
      $error("FAIL %s count=%0d expected %0d", tag, c, ec);
    end
    assert (b === eb) else begin
      failures++;
      $error("FAIL %s busy=%b expected %b", tag, b, eb);
    end
    assert (d === ed) else begin
      failures++;
      $error("FAIL %s done=%b expected %b", tag, d, ed);
    end
  endtask

  task automatic c0(input string tag, input logic [3:0] ec, input logic eb, input logic ed);
    chk(tag, if0.count, if0.busy, if0.done, ec, eb, ed);
  endtask

  task automatic c1(input string tag, input logic [3:0] ec, input logic eb, input logic ed);
    chk(tag, if1.count, if1.busy, if1.done, ec, eb, ed);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    if0.clear = 1'b0; if0.load = 1'b0; if0.load_val = '0; if0.hold = 1'b0;
    if1.clear = 1'b0; if1.load = 1'b0; if1.load_val = '0; if1.hold = 1'b0;
    tick();
    c0("reset0", 4'd0, 1'b0, 1'b0);
    c1("reset1", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    c0("idle_after_reset", 4'd0, 1'b0, 1'b0);

    // 1: load 5
    if0.load = 1'b1; if0.load_val = 4'd5;
    tick(); if0.load = 1'b0;
    c0("t1_5", 4'd5, 1'b1, 1'b0);
    tick(); c0("t1_4", 4'd4, 1'b1, 1'b0);
    tick(); c0("t1_3", 4'd3, 1'b1, 1'b0);
    tick(); c0("t1_2", 4'd2, 1'b1, 1'b0);
    tick(); c0("t1_1", 4'd1, 1'b1, 1'b0);
    tick(); c0("t1_done", 4'd0, 1'b0, 1'b1);
    tick(); c0("t1_idle", 4'd0, 1'b0, 1'b0);
    tick(); c0("t1_idle2", 4'd0, 1'b0, 1'b0);

    // 2: load 3 with two hold cycles
    if0.load = 1'b1; if0.load_val = 4'd3;
    tick(); if0.load = 1'b0;
    c0("t2_3", 4'd3, 1'b1, 1'b0);
    tick(); c0("t2_2", 4'd2, 1'b1, 1'b0);
    if0.hold = 1'b1;
    tick(); c0("t2_hold_a", 4'd2, 1'b1, 1'b0);
    tick(); c0("t2_hold_b", 4'd2, 1'b1, 1'b0);
    if0.hold = 1'b0;
    tick(); c0("t2_1", 4'd1, 1'b1, 1'b0);
    tick(); c0("t2_done", 4'd0, 1'b0, 1'b1);
    tick(); c0("t2_idle", 4'd0, 1'b0, 1'b0);

    // 3: load 6, restart with 2 at count 3
    if0.load = 1'b1; if0.load_val = 4'd6;
    tick(); if0.load = 1'b0;
    c0("t3_6", 4'd6, 1'b1, 1'b0);
    tick(); c0("t3_5", 4'd5, 1'b1, 1'b0);
    tick(); c0("t3_4", 4'd4, 1'b1, 1'b0);
    tick(); c0("t3_3", 4'd3, 1'b1, 1'b0);
    if0.load = 1'b1; if0.load_val = 4'd2;
    tick(); if0.load = 1'b0;
    c0("t3_re2", 4'd2, 1'b1, 1'b0);
    tick(); c0("t3_re1", 4'd1, 1'b1, 1'b0);
    tick(); c0("t3_done", 4'd0, 1'b0, 1'b1);
    tick(); c0("t3_idle", 4'd0, 1'b0, 1'b0);

    // 4: load 4, clear+load at count 2
    if0.load = 1'b1; if0.load_val = 4'd4;
    tick(); if0.load = 1'b0;
    c0("t4_4", 4'd4, 1'b1, 1'b0);
    tick(); c0("t4_3", 4'd3, 1'b1, 1'b0);
    tick(); c0("t4_2", 4'd2, 1'b1, 1'b0);
    if0.clear = 1'b1; if0.load = 1'b1; if0.load_val = 4'd7;
    tick(); if0.clear = 1'b0; if0.load = 1'b0;
    c0("t4_clear", 4'd0, 1'b0, 1'b0);
    tick(); c0("t4_nodone_a", 4'd0, 1'b0, 1'b0);
    tick(); c0("t4_nodone_b", 4'd0, 1'b0, 1'b0);
    // hold has no effect in IDLE
    if0.hold = 1'b1;
    tick(); c0("t4_idle_hold", 4'd0, 1'b0, 1'b0);
    if0.hold = 1'b0;

    // 5: auto-reload instance
    if1.load = 1'b1; if1.load_val = 4'd2;
    tick(); if1.load = 1'b0;
    c1("t5_2a", 4'd2, 1'b1, 1'b0);
    tick(); c1("t5_1a", 4'd1, 1'b1, 1'b0);
    tick(); c1("t5_done_a", 4'd0, 1'b0, 1'b1);
    tick(); c1("t5_2b", 4'd2, 1'b1, 1'b0);
    tick(); c1("t5_1b", 4'd1, 1'b1, 1'b0);
    tick(); c1("t5_done_b", 4'd0, 1'b0, 1'b1);
    // hold is ignored in DONE: reload still happens
    if1.hold = 1'b1;
    tick(); c1("t5_2c_hold", 4'd2, 1'b1, 1'b0);
    tick(); c1("t5_held", 4'd2, 1'b1, 1'b0);
    if1.hold = 1'b0;
    tick(); c1("t5_1c", 4'd1, 1'b1, 1'b0);
    if1.load = 1'b1; if1.load_val = 4'd0;
    tick(); if1.load = 1'b0;
    c1("t5_load0_done", 4'd0, 1'b0, 1'b1);
    tick(); c1("t5_load0_idle", 4'd0, 1'b0, 1'b0);
    tick(); c1("t5_load0_idle2", 4'd0, 1'b0, 1'b0);

    // 6: load 0 without auto-reload, then async reset mid-run
    if0.load = 1'b1; if0.load_val = 4'd0;
    tick(); if0.load = 1'b0;
    c0("t6_load0_done", 4'd0, 1'b0, 1'b1);
    tick(); c0("t6_load0_idle", 4'd0, 1'b0, 1'b0);
    if0.load = 1'b1; if0.load_val = 4'd5;
    tick(); if0.load = 1'b0;
    c0("t6_5", 4'd5, 1'b1, 1'b0);
    tick(); c0("t6_4", 4'd4, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 c0("t6_async_rst", 4'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick(); c0("t6_after_rst", 4'd0, 1'b0, 1'b0);
    tick(); c0("t6_after_rst2", 4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
